// File: rtl/pmem_line_responder.sv
// Memory-side responder for whole-line pmem reads/writes, backed by a 2**IDX_W-line array; `PMEM_STATS_EN adds op counters.
// Latency: pmem_resp pulses LATENCY cycles after the request is accepted in IDLE.
// Backpressure: one op in flight; requests are ignored outside IDLE.
module pmem_line_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [7:0]         wait_cnt;
  logic               op_write;
  logic [IDX_W-1:0]   line_idx;
  logic [255:0]       line_buf;
  logic [255:0]       mem [2**IDX_W];

  // Offset bits and alias bits above the index are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^pmem_address;

  if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
    $error("pmem_line_responder: LATENCY must be in 2..255");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      op_write   <= 1'b0;
      line_idx   <= '0;
      line_buf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
          if (pmem_read || pmem_write) begin
            // Write wins when both strobes are high.
            op_write <= pmem_write;
            line_idx <= pmem_address[5+IDX_W-1:5];
            line_buf <= pmem_wdata;
            wait_cnt <= 8'(LATENCY - 2);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt == 8'd0) begin
            state     <= DONE;
            pmem_resp <= 1'b1;
            if (!op_write) pmem_rdata <= mem[line_idx];
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        DONE: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit at the DONE edge; a reset in that cycle cancels the write.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && op_write) mem[line_idx] <= line_buf;
  end

`ifdef PMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (!op_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized bench for pmem_line_responder against a line-array reference model.
module tb_pmem_line_responder;
  localparam int LAT   = 4;
  localparam int IDX_W = 8;
`ifdef PMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  rd_count, wr_count;

  pmem_line_responder #(.LATENCY(LAT), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [255:0] model_mem [int];
  int exp_rd = 0;
  int exp_wr = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [15:0] a);
    return int'(a) / 32 % (2**IDX_W);
  endfunction

  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One op: asserted the cycle after the call's first edge, held until resp.
  // drop: strobes and data corrupted after the accept cycle; abort: reset in DONE.
  task automatic do_op(input bit rd, input bit wr, input logic [15:0] a, input logic [255:0] d,
                       input bit drop, input bit abort, output logic [255:0] got);
    int k;
    @(posedge clk); #1;
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = d;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (drop && k == 1) begin
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = ~a; pmem_wdata = ~d;
      end
    end while (!pmem_resp && k < LAT + 20);
    check("latency", 256'(k), 256'(LAT));
    got = pmem_rdata;
    pmem_read = 1'b0; pmem_write = 1'b0;
    if (abort) begin
      reset = 1'b1;
      exp_rd = 0; exp_wr = 0;
    end else if (pmem_resp) begin
      if (wr) begin
        model_mem[idx_of(a)] = d;
        exp_wr++;
      end else begin
        if (model_mem.exists(idx_of(a))) check("rdata", pmem_rdata, model_mem[idx_of(a)]);
        exp_rd++;
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_rd"}, 256'(rd_count), STATS ? 256'(exp_rd) : 256'(0));
    check({tag, "_wr"}, 256'(wr_count), STATS ? 256'(exp_wr) : 256'(0));
  endtask

  initial begin
    logic [255:0] got, x_line, w_line, hold;
    int resp_seen;
    reset = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_resp", 256'(pmem_resp), 256'(0));
    check("rst_rdata", pmem_rdata, '0);
    check_stats("rst_cnt");
    resp_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pmem_resp) resp_seen++;
    end
    check("idle_resp", 256'(resp_seen), 256'(0));

    do_op(1'b0, 1'b1, 16'h0040, fill(8'hA5), 1'b0, 1'b0, got);
    do_op(1'b1, 1'b0, 16'h0040, '0, 1'b0, 1'b0, got);
    check("a5_read", got, fill(8'hA5));

    // Read asserted the cycle right after the write's resp.
    x_line = rand_line();
    do_op(1'b0, 1'b1, 16'h0020, x_line, 1'b0, 1'b0, got);
    do_op(1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0, got);
    check("b2b_read", got, x_line);
    @(posedge clk); #1;
    check("rdata_hold", pmem_rdata, x_line);

    x_line = rand_line();
    do_op(1'b0, 1'b1, 16'h0020, x_line, 1'b0, 1'b0, got);
    do_op(1'b1, 1'b0, 16'h2020, '0, 1'b0, 1'b0, got);
    check("alias_hi", got, x_line);
    do_op(1'b1, 1'b0, 16'h003F, '0, 1'b0, 1'b0, got);
    check("alias_lo", got, x_line);

    // Reset in DONE of a write of Z over W leaves W in place.
    w_line = rand_line();
    do_op(1'b0, 1'b1, 16'h0100, w_line, 1'b0, 1'b0, got);
    do_op(1'b0, 1'b1, 16'h0100, rand_line(), 1'b0, 1'b1, got);
    @(posedge clk); #1;
    check("abort_resp", 256'(pmem_resp), 256'(0));
    check_stats("abort_cnt");
    reset = 1'b0;
    do_op(1'b1, 1'b0, 16'h0100, '0, 1'b0, 1'b0, got);
    check("abort_keep", got, w_line);

    // Both strobes high: write, and rdata must not change.
    hold = pmem_rdata;
    x_line = rand_line();
    do_op(1'b1, 1'b1, 16'h0200, x_line, 1'b0, 1'b0, got);
    check("both_no_rdata", got, hold);
    do_op(1'b1, 1'b0, 16'h0200, '0, 1'b0, 1'b0, got);
    check("both_is_write", got, x_line);

    // Inputs dropped and scrambled mid-BUSY: captured values still land.
    x_line = rand_line();
    do_op(1'b0, 1'b1, 16'h0300, x_line, 1'b1, 1'b0, got);
    do_op(1'b1, 1'b0, 16'h0300, '0, 1'b1, 1'b0, got);
    check("drop_read", got, x_line);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      int op;
      a = 16'($urandom);
      a[12:5] = 8'($urandom_range(0, 15));
      op = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(op <= 1, op >= 2, a, rand_line(), $urandom_range(0, 9) == 0, 1'b0, got);
    end
    check_stats("final_cnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
